// File: rtl/aes_round_sched_pkg.sv
// Shared definitions for the AES-128 round scheduler: stage indices,
// FSM encoding and the default round count.
package aes_round_sched_pkg;

  localparam int AES_NR_128 = 10;

  localparam logic [1:0] STG_SB  = 2'd0;
  localparam logic [1:0] STG_SR  = 2'd1;
  localparam logic [1:0] STG_MC  = 2'd2;
  localparam logic [1:0] STG_ARK = 2'd3;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_ISSUE_SB  = 4'd1,
    ST_WAIT_SB   = 4'd2,
    ST_ISSUE_SR  = 4'd3,
    ST_WAIT_SR   = 4'd4,
    ST_ISSUE_MC  = 4'd5,
    ST_WAIT_MC   = 4'd6,
    ST_ISSUE_ARK = 4'd7,
    ST_WAIT_ARK  = 4'd8,
    ST_DONE      = 4'd9
  } state_e;

endpackage

// File: rtl/aes_round_sched_watchdog.sv
// Stage-ready watchdog: cleared on issue, counts wait cycles, flags expiry
// on the wait cycle that brings the count to TIMEOUT. Saturates, never wraps.
module aes_stage_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_in,
  input  logic en_in,
  output logic expire_out
);

  localparam logic [7:0] LIMIT = 8'(TIMEOUT - 1);

  logic [7:0] cnt_q, cnt_d;

  // next count: clear wins, otherwise saturating increment while enabled
  always_comb begin
    cnt_d = cnt_q;
    if (clr_in) begin
      cnt_d = 8'd0;
    end else if (en_in && (cnt_q != 8'hFF)) begin
      cnt_d = cnt_q + 8'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  assign expire_out = en_in && (cnt_q == LIMIT);

  // counter register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/aes_round_sched.sv
// AES-128 round scheduler: owns the cipher state and sequences the SB/SR/MC/ARK
// stage blocks through their start/ready pulse handshake, one stage at a time.
module aes_round_sched
  import aes_round_sched_pkg::*;
#(
  parameter int NR      = AES_NR_128,
  parameter int TIMEOUT = 255
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start_in,
  input  logic [127:0] data_in,
  output logic [3:0]   stg_start_out,
  output logic [127:0] stg_data_out,
  input  logic [3:0]   stg_ready_in,
  input  logic [511:0] stg_result_in,
  output logic [3:0]   key_idx_out,
  output logic [3:0]   round_out,
  output logic         busy_out,
  output logic         done_out,
  output logic         err_out,
  output logic [127:0] data_out
);

  localparam logic [3:0] NR_L = 4'(NR);

  state_e         state_q, state_d;
  logic [127:0]   cipher_q, cipher_d;
  logic [127:0]   data_out_q, data_out_d;
  logic [3:0]     round_q, round_d;
  logic [3:0]     stg_start_q, stg_start_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           err_q, err_d;

  logic [1:0]     wait_idx;
  logic           in_wait;
  logic           in_issue;
  logic           ready_hit;
  logic           expire;
  logic [127:0]   result_sel;

  // decode which stage (if any) is being issued or awaited
  always_comb begin
    wait_idx = STG_SB;
    in_wait  = 1'b0;
    in_issue = 1'b0;
    case (state_q)
      ST_ISSUE_SB, ST_ISSUE_SR, ST_ISSUE_MC, ST_ISSUE_ARK: in_issue = 1'b1;
      ST_WAIT_SB:  begin in_wait = 1'b1; wait_idx = STG_SB;  end
      ST_WAIT_SR:  begin in_wait = 1'b1; wait_idx = STG_SR;  end
      ST_WAIT_MC:  begin in_wait = 1'b1; wait_idx = STG_MC;  end
      ST_WAIT_ARK: begin in_wait = 1'b1; wait_idx = STG_ARK; end
      default:     begin in_wait = 1'b0; end
    endcase
  end

  assign result_sel = stg_result_in[{wait_idx, 7'd0} +: 128];
  assign ready_hit  = in_wait && stg_ready_in[wait_idx];

  aes_stage_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk        (clk),
    .rst        (rst),
    .clr_in     (in_issue),
    .en_in      (in_wait),
    .expire_out (expire)
  );

  // sequencing: ready beats a same-cycle timeout
  always_comb begin
    state_d    = state_q;
    cipher_d   = cipher_q;
    data_out_d = data_out_q;
    round_d    = round_q;
    busy_d     = busy_q;
    err_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_in) begin
          state_d  = ST_ISSUE_ARK;
          cipher_d = data_in;
          round_d  = 4'd0;
          busy_d   = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE_SB:  state_d = ST_WAIT_SB;
      ST_ISSUE_SR:  state_d = ST_WAIT_SR;
      ST_ISSUE_MC:  state_d = ST_WAIT_MC;
      ST_ISSUE_ARK: state_d = ST_WAIT_ARK;
      ST_WAIT_SB, ST_WAIT_SR, ST_WAIT_MC, ST_WAIT_ARK: begin
        if (ready_hit) begin
          cipher_d = result_sel;
          if (state_q == ST_WAIT_SB) begin
            state_d = ST_ISSUE_SR;
          end else if (state_q == ST_WAIT_SR) begin
            state_d = (round_q == NR_L) ? ST_ISSUE_ARK : ST_ISSUE_MC;
          end else if (state_q == ST_WAIT_MC) begin
            state_d = ST_ISSUE_ARK;
          end else if (round_q == NR_L) begin
            state_d    = ST_DONE;
            data_out_d = result_sel;
            busy_d     = 1'b0;
          end else begin
            state_d = ST_ISSUE_SB;
            round_d = round_q + 4'd1;
          end
        end else if (expire) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          err_d   = 1'b1;
        end else begin
          state_d = state_q;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // registered one-hot start and done strobe follow the next state
  always_comb begin
    stg_start_d = 4'b0000;
    done_d      = 1'b0;
    case (state_d)
      ST_ISSUE_SB:  stg_start_d = 4'b0001;
      ST_ISSUE_SR:  stg_start_d = 4'b0010;
      ST_ISSUE_MC:  stg_start_d = 4'b0100;
      ST_ISSUE_ARK: stg_start_d = 4'b1000;
      ST_DONE:      done_d      = 1'b1;
      default:      stg_start_d = 4'b0000;
    endcase
  end

  // state and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      cipher_q    <= 128'd0;
      data_out_q  <= 128'd0;
      round_q     <= 4'd0;
      stg_start_q <= 4'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cipher_q    <= cipher_d;
      data_out_q  <= data_out_d;
      round_q     <= round_d;
      stg_start_q <= stg_start_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign stg_start_out = stg_start_q;
  assign stg_data_out  = cipher_q;
  assign key_idx_out   = round_q;
  assign round_out     = round_q;
  assign busy_out      = busy_q;
  assign done_out      = done_q;
  assign err_out       = err_q;
  assign data_out      = data_out_q;

endmodule

// File: tb/tb_aes_round_sched.sv
// Bench for aes_round_sched: stub stages with programmable latency, and a
// timing model that predicts every output cycle by cycle from the round schedule.
module tb_aes_round_sched;

  localparam int NR  = 10;
  localparam int BIG = 32'h3fff_ffff;

  logic         clk = 1'b0;
  logic         rst;
  logic         start_in;
  logic [127:0] data_in;
  logic [3:0]   stg_start_out;
  logic [127:0] stg_data_out;
  logic [3:0]   stg_ready_in;
  logic [511:0] stg_result_in;
  logic [3:0]   key_idx_out;
  logic [3:0]   round_out;
  logic         busy_out;
  logic         done_out;
  logic         err_out;
  logic [127:0] data_out;

  aes_round_sched #(.NR(NR), .TIMEOUT(255)) dut (
    .clk           (clk),
    .rst           (rst),
    .start_in      (start_in),
    .data_in       (data_in),
    .stg_start_out (stg_start_out),
    .stg_data_out  (stg_data_out),
    .stg_ready_in  (stg_ready_in),
    .stg_result_in (stg_result_in),
    .key_idx_out   (key_idx_out),
    .round_out     (round_out),
    .busy_out      (busy_out),
    .done_out      (done_out),
    .err_out       (err_out),
    .data_out      (data_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  // stub stage state and configuration
  int           lat = 1;
  bit           mute_en = 1'b0;
  bit           noise_en = 1'b0;
  logic [127:0] kinc [4];
  bit           pend [4];
  bit           muted [4];
  int           rem [4];
  logic [127:0] cap [4];
  logic [127:0] res [4];

  // expected schedule of the current run
  int           t0 = BIG;
  int           end_c = BIG;
  bit           err_run = 1'b0;
  bit           pin_en = 1'b0;
  int           pin_len = 0;
  int           seq_len = 0;
  logic [127:0] exp_final = 128'd0;
  logic [127:0] prev_data = 128'd0;
  int           seq_stage [44];
  int           seq_round [44];
  logic [127:0] seq_data [44];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cycle %0d: got %h, want %h", nm, cyc, act, exp);
    end
  endtask

  // stages answer L cycles after their start with captured input + kinc
  task automatic stub_step();
    logic [3:0] rdy;
    rdy = 4'b0000;
    for (int x = 0; x < 4; x++) begin
      if (pend[x] && !muted[x]) begin
        rem[x]--;
        if (rem[x] == 0) begin
          rdy[x]  = 1'b1;
          res[x]  = cap[x] + kinc[x];
          pend[x] = 1'b0;
        end
      end
      if (stg_start_out[x]) begin
        pend[x]  = 1'b1;
        rem[x]   = lat;
        cap[x]   = stg_data_out;
        muted[x] = mute_en && (x == 1) && (round_out == 4'd3);
      end
      if (noise_en && !pend[x] && !rdy[x]) begin
        rdy[x] = 1'($urandom_range(0, 1));
        res[x] = {$urandom(), $urandom(), $urandom(), $urandom()};
      end
    end
    stg_ready_in = rdy;
    for (int x = 0; x < 4; x++) stg_result_in[x*128 +: 128] = res[x];
  endtask

  task automatic tick(input bit inj);
    @(negedge clk);
    start_in = inj && (cyc == t0 + 19 || cyc == end_c);
    data_in  = {$urandom(), $urandom(), $urandom(), $urandom()};
    stub_step();
  endtask

  // launch a run and build its expected schedule from the round rules
  task automatic start_run(input logic [127:0] d, input int lat_i, input bit mute_i,
                           input bit noise_i, input bit pin_i, input int pin_len_i);
    logic [127:0] acc;
    int n;
    int p;
    @(negedge clk);
    prev_data = (cyc >= end_c && !err_run) ? exp_final : prev_data;
    lat = lat_i; mute_en = mute_i; noise_en = noise_i;
    pin_en = pin_i; pin_len = pin_len_i;
    for (int x = 0; x < 4; x++) begin pend[x] = 1'b0; muted[x] = 1'b0; end
    acc = d; n = 0;
    for (int r = 0; r <= NR; r++) begin
      for (int s = 0; s < 4; s++) begin
        if ((r == 0 && s != 3) || (r == NR && s == 2)) continue;
        seq_stage[n] = (r == 0) ? 3 : s;
        seq_round[n] = r;
        seq_data[n]  = acc;
        acc = acc + kinc[seq_stage[n]];
        n++;
      end
    end
    p = lat_i + 1;
    t0 = cyc + 1;
    if (mute_i) begin
      seq_len = 11; err_run = 1'b1; end_c = t0 + 10 * p + 256;
    end else begin
      seq_len = n; err_run = 1'b0; end_c = t0 + n * p; exp_final = acc;
    end
    start_in = 1'b1; data_in = d;
    stub_step();
  endtask

  task automatic finish_run(input bit inj);
    while (cyc < end_c + 4) tick(inj);
  endtask

  int m_c, m_k, m_p;
  logic [3:0] m_exp;
  int cnt [4];
  int mc10;

  // compare every cycle against the schedule model
  always @(posedge clk) begin
    #1;
    m_c = cyc;
    if (!rst) begin
      chk("rst_ctrl", 128'({stg_start_out, key_idx_out, round_out, busy_out, done_out, err_out}), 128'd0);
      chk("rst_data_out", data_out, 128'd0);
      chk("rst_stg_data", stg_data_out, 128'd0);
    end else begin
      m_p = lat + 1; m_exp = 4'b0000; m_k = -1;
      if (m_c >= t0 && m_c < end_c && ((m_c - t0) % m_p) == 0 && ((m_c - t0) / m_p) < seq_len) begin
        m_k = (m_c - t0) / m_p;
        m_exp = 4'(4'b0001 << seq_stage[m_k]);
      end
      chk("stg_start", 128'(stg_start_out), 128'(m_exp));
      if (m_k >= 0) begin
        chk("key_idx", 128'(key_idx_out), 128'(seq_round[m_k]));
        chk("round", 128'(round_out), 128'(seq_round[m_k]));
        chk("stg_data", stg_data_out, seq_data[m_k]);
      end
      chk("busy", 128'(busy_out), 128'(m_c >= t0 && m_c < end_c));
      chk("done", 128'(done_out), 128'(m_c == end_c && !err_run));
      chk("err", 128'(err_out), 128'(m_c == end_c && err_run));
      chk("data_out", data_out, (m_c >= end_c && !err_run) ? exp_final : prev_data);
      if (m_c == t0) begin
        for (int x = 0; x < 4; x++) cnt[x] = 0;
        mc10 = 0;
        if (pin_en) begin
          chk("pin_done_cycle", 128'(end_c - t0), 128'(pin_len));
          chk("pin_final", exp_final, 128'h28);
        end
      end
      for (int x = 0; x < 4; x++) if (stg_start_out[x]) cnt[x]++;
      if (stg_start_out[2] && round_out == 4'd10) mc10++;
      if (m_c == end_c && !err_run) begin
        chk("cnt_sb_sr_mc_ark", 128'({cnt[0][7:0], cnt[1][7:0], cnt[2][7:0], cnt[3][7:0]}),
            128'({8'd10, 8'd10, 8'd9, 8'd11}));
        chk("mc_in_round10", 128'(mc10), 128'd0);
      end
    end
  end

  initial begin
    rst = 1'b0; start_in = 1'b0; data_in = 128'd0;
    stg_ready_in = 4'd0; stg_result_in = 512'd0;
    for (int x = 0; x < 4; x++) begin
      kinc[x] = 128'd1; pend[x] = 1'b0; muted[x] = 1'b0; rem[x] = 0;
      cap[x] = 128'd0; res[x] = 128'd0;
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (3) tick(1'b0);

    // L=1 and L=3 baseline runs from zero plaintext
    start_run(128'd0, 1, 1'b0, 1'b0, 1'b1, 80);
    finish_run(1'b0);
    start_run(128'd0, 3, 1'b0, 1'b0, 1'b1, 160);
    finish_run(1'b0);

    // extra start pulses mid-run and in the done cycle are ignored
    start_run(128'd0, 1, 1'b0, 1'b0, 1'b1, 80);
    finish_run(1'b1);

    // SR never answers in round 3
    start_run(128'd0, 2, 1'b1, 1'b0, 1'b0, 0);
    finish_run(1'b0);

    // async reset in the middle of round 5, then a clean run
    start_run(128'd0, 1, 1'b0, 1'b0, 1'b0, 0);
    while (cyc < t0 + 36) tick(1'b0);
    @(negedge clk);
    rst = 1'b0; start_in = 1'b0;
    t0 = BIG; end_c = BIG; err_run = 1'b0; prev_data = 128'd0;
    for (int x = 0; x < 4; x++) begin pend[x] = 1'b0; muted[x] = 1'b0; end
    stg_ready_in = 4'd0;
    repeat (2) tick(1'b0);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) tick(1'b0);
    start_run(128'd0, 1, 1'b0, 1'b0, 1'b1, 80);
    finish_run(1'b0);

    // random plaintext, latency, per-stage increments, spurious ready noise
    for (int i = 0; i < 6; i++) begin
      for (int x = 0; x < 4; x++) kinc[x] = {$urandom(), $urandom(), $urandom(), $urandom()};
      start_run({$urandom(), $urandom(), $urandom(), $urandom()},
                int'($urandom_range(1, 4)), 1'b0, 1'b1, 1'b0, 0);
      finish_run(1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
